// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, controller states and flags.
package alu_pkg;

  localparam logic [4:0] OP_TRANSFER = 5'h00;
  localparam logic [4:0] OP_INC      = 5'h01;
  localparam logic [4:0] OP_DEC      = 5'h02;
  localparam logic [4:0] OP_ADD      = 5'h03;
  localparam logic [4:0] OP_SUB      = 5'h04;
  localparam logic [4:0] OP_AND      = 5'h05;
  localparam logic [4:0] OP_OR       = 5'h06;
  localparam logic [4:0] OP_XOR      = 5'h07;
  localparam logic [4:0] OP_NOT      = 5'h08;
  localparam logic [4:0] OP_SHL      = 5'h09;
  localparam logic [4:0] OP_SHR      = 5'h0A;
  localparam logic [4:0] OP_ASR      = 5'h0B;
  localparam logic [4:0] OP_RCL      = 5'h0C;
  localparam logic [4:0] OP_RCR      = 5'h0D;
  localparam logic [4:0] OP_BSWAP    = 5'h0E;
  localparam logic [4:0] OP_MUL      = 5'h10;
  localparam logic [4:0] OP_DIV      = 5'h11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } alu_state_t;

  typedef struct packed {
    logic c;
    logic z;
    logic s;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/alu_mc_if.sv
// Request/result bundle between the microsequencer (master) and the ALU (slave).
interface alu_mc_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [4:0]       fsel;
  logic [WIDTH-1:0] abus;
  logic [WIDTH-1:0] bbus;
  logic             cin;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] fout;
  logic [WIDTH-1:0] fout_hi;
  logic             c;
  logic             z;
  logic             s;
  logic             v;

  modport master (
    output start, fsel, abus, bbus, cin,
    input  busy, done, err, fout, fout_hi, c, z, s, v
  );

  modport slave (
    input  start, fsel, abus, bbus, cin,
    output busy, done, err, fout, fout_hi, c, z, s, v
  );
endinterface

// File: rtl/alu_mc_iter.sv
// Shared shift/add (MUL) and restoring shift/subtract (DIV) iteration datapath.
// The divide path exists only when ALU_MC_DIV_EN is defined.
module alu_mc_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
`ifdef ALU_MC_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] sr_reg, sr_next;
  logic [WIDTH-1:0] b_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH:0]   mul_sum;
`ifdef ALU_MC_DIV_EN
  logic             div_reg;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_diff;
`endif

  always_comb begin
    // MUL: LSB-first; the product shifts right through {acc, sr}
    mul_sum  = {1'b0, acc_reg} + {1'b0, b_reg & {WIDTH{sr_reg[0]}}};
    acc_next = mul_sum[WIDTH:1];
    sr_next  = {mul_sum[0], sr_reg[MSB:1]};
`ifdef ALU_MC_DIV_EN
    // DIV: the partial remainder is below B, so its low WIDTH bits are exact
    rem_sh   = {acc_reg, sr_reg[MSB]};
    rem_ge   = (rem_sh >= {1'b0, b_reg});
    rem_diff = rem_sh[MSB:0] - b_reg;
    if (div_reg) begin
      acc_next = rem_ge ? rem_diff : rem_sh[MSB:0];
      sr_next  = {sr_reg[MSB-1:0], rem_ge};
    end
`endif
  end

  assign last   = (cnt_reg == CNT_W'(WIDTH - 1));
  assign res_hi = acc_next;
  assign res_lo = sr_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
      sr_reg  <= '0;
      b_reg   <= '0;
      cnt_reg <= '0;
`ifdef ALU_MC_DIV_EN
      div_reg <= 1'b0;
`endif
    end else if (load) begin
      acc_reg <= '0;
      sr_reg  <= a;
      b_reg   <= b;
      cnt_reg <= '0;
`ifdef ALU_MC_DIV_EN
      div_reg <= is_div;
`endif
    end else if (step) begin
      acc_reg <= acc_next;
      sr_reg  <= sr_next;
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: 15 single-cycle ops plus iterative MUL and optional DIV.
// Define ALU_MC_DIV_EN to build the divider; otherwise FSEL 0x11 is illegal.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic     clk,
  input  logic     rst,
  alu_mc_if.slave  bus
);
  localparam int MSB      = WIDTH - 1;
  localparam bit BSWAP_OK = (WIDTH % 8) == 0;

  alu_state_t       state_reg;
  logic             busy_reg, done_reg, err_reg;
  logic [WIDTH-1:0] fout_reg, fout_hi_reg;
  alu_flags_t       flags_reg;

  logic [WIDTH-1:0] a, b, bswap_val, sc_res;
  logic [WIDTH:0]   add_sum, sub_diff, inc_sum, dec_diff;
  logic             sc_c, sc_v, sc_legal;
  alu_flags_t       sc_flags, mc_flags;
  logic             is_mul, is_div, iter_load, iter_last;
  logic [WIDTH-1:0] iter_hi, iter_lo;
`ifdef ALU_MC_DIV_EN
  logic             div_op_reg, bzero_reg;
`endif

  assign a = bus.abus;
  assign b = bus.bbus;

  assign add_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, bus.cin};
  assign sub_diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bus.cin};
  assign inc_sum  = {1'b0, a} + (WIDTH + 1)'(1);
  assign dec_diff = {1'b0, a} - (WIDTH + 1)'(1);

  generate
    if (BSWAP_OK) begin : g_bswap
      for (genvar gi = 0; gi < WIDTH / 8; gi++) begin : g_byte
        assign bswap_val[gi*8 +: 8] = a[WIDTH-8-gi*8 +: 8];
      end
    end else begin : g_no_bswap
      assign bswap_val = '0;
    end
  endgenerate

  assign is_mul = (bus.fsel == OP_MUL);
`ifdef ALU_MC_DIV_EN
  assign is_div = (bus.fsel == OP_DIV);
`else
  assign is_div = 1'b0;
`endif
  assign iter_load = bus.start && (state_reg == ST_IDLE) && (is_mul || is_div);

  // Illegal selects fall through with a zero result, which yields Z=1 and C=S=V=0
  always_comb begin
    sc_res   = '0;
    sc_c     = 1'b0;
    sc_v     = 1'b0;
    sc_legal = 1'b1;
    case (bus.fsel)
      OP_TRANSFER: sc_res = a;
      OP_INC: begin
        sc_res = inc_sum[MSB:0];
        sc_c   = inc_sum[WIDTH];
        sc_v   = ~a[MSB] & sc_res[MSB];
      end
      OP_DEC: begin
        sc_res = dec_diff[MSB:0];
        sc_c   = dec_diff[WIDTH];
        sc_v   = a[MSB] & ~sc_res[MSB];
      end
      OP_ADD: begin
        sc_res = add_sum[MSB:0];
        sc_c   = add_sum[WIDTH];
        sc_v   = (a[MSB] == b[MSB]) && (sc_res[MSB] != a[MSB]);
      end
      OP_SUB: begin
        sc_res = sub_diff[MSB:0];
        sc_c   = sub_diff[WIDTH];
        sc_v   = (a[MSB] != b[MSB]) && (sc_res[MSB] != a[MSB]);
      end
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_NOT:  sc_res = ~a;
      OP_SHL: begin
        sc_res = {a[MSB-1:0], 1'b0};
        sc_c   = a[MSB];
      end
      OP_SHR: begin
        sc_res = {1'b0, a[MSB:1]};
        sc_c   = a[0];
      end
      OP_ASR: begin
        sc_res = {a[MSB], a[MSB:1]};
        sc_c   = a[0];
      end
      OP_RCL: begin
        sc_res = {a[MSB-1:0], bus.cin};
        sc_c   = a[MSB];
      end
      OP_RCR: begin
        sc_res = {bus.cin, a[MSB:1]};
        sc_c   = a[0];
      end
      OP_BSWAP: begin
        if (BSWAP_OK) sc_res = bswap_val;
        else          sc_legal = 1'b0;
      end
      default: sc_legal = 1'b0;
    endcase
    sc_flags.c = sc_c;
    sc_flags.z = (sc_res == '0);
    sc_flags.s = sc_res[MSB];
    sc_flags.v = sc_v;
  end

  always_comb begin
    mc_flags.c = (iter_hi != '0);
    mc_flags.v = (iter_hi != '0);
    mc_flags.s = iter_hi[MSB];
    mc_flags.z = (iter_hi == '0) && (iter_lo == '0);
`ifdef ALU_MC_DIV_EN
    if (div_op_reg) begin
      mc_flags.c = 1'b0;
      mc_flags.v = bzero_reg;
      mc_flags.s = iter_lo[MSB];
    end
`endif
  end

  alu_mc_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (iter_load),
    .step   (state_reg == ST_EXEC),
`ifdef ALU_MC_DIV_EN
    .is_div (is_div),
`endif
    .a      (a),
    .b      (b),
    .last   (iter_last),
    .res_hi (iter_hi),
    .res_lo (iter_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      fout_reg    <= '0;
      fout_hi_reg <= '0;
      flags_reg   <= '{c: 1'b0, z: 1'b1, s: 1'b0, v: 1'b0};
`ifdef ALU_MC_DIV_EN
      div_op_reg  <= 1'b0;
      bzero_reg   <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            if (is_mul || is_div) begin
              state_reg  <= ST_EXEC;
              busy_reg   <= 1'b1;
`ifdef ALU_MC_DIV_EN
              div_op_reg <= is_div;
              bzero_reg  <= (b == '0);
`endif
            end else begin
              done_reg    <= 1'b1;
              err_reg     <= ~sc_legal;
              fout_reg    <= sc_res;
              fout_hi_reg <= '0;
              flags_reg   <= sc_flags;
            end
          end
        end
        ST_EXEC: begin
          if (iter_last) begin
            state_reg   <= ST_IDLE;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
            fout_reg    <= iter_lo;
            fout_hi_reg <= iter_hi;
            flags_reg   <= mc_flags;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.err     = err_reg;
  assign bus.fout    = fout_reg;
  assign bus.fout_hi = fout_hi_reg;
  assign bus.c       = flags_reg.c;
  assign bus.z       = flags_reg.z;
  assign bus.s       = flags_reg.s;
  assign bus.v       = flags_reg.v;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed corner cases plus random ops against an
// arithmetic reference model; a second WIDTH=32 instance covers the parametric MUL.
module tb_alu_mc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(16)) b16 ();
  alu_mc_if #(.WIDTH(32)) b32 ();

  alu_mc #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  alu_mc #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));

  typedef struct {
    logic [15:0] hi;
    logic [15:0] lo;
    logic        c, z, s, v, err;
  } res_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_iter(input logic [4:0] f);
`ifdef ALU_MC_DIV_EN
    return (f == 5'h10) || (f == 5'h11);
`else
    return (f == 5'h10);
`endif
  endfunction

  // Reference computed with plain integer arithmetic on the operand values
  function automatic res_t model(input logic [4:0] f, input logic [15:0] a,
                                 input logic [15:0] b, input logic ci);
    res_t   r;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint cl = longint'(ci);
    longint t;
    int     sa = int'($signed(a));
    int     sb = int'($signed(b));
    int     cv = int'(ci);
    int     st;
    r.hi = 0; r.lo = 0; r.c = 0; r.v = 0; r.err = 0;
    case (f)
      5'h00: r.lo = a;
      5'h01: begin t = ua + 1; r.lo = t[15:0]; r.c = t[16]; r.v = (sa + 1 > 32767); end
      5'h02: begin t = ua - 1; r.lo = t[15:0]; r.c = (ua < 1); r.v = (sa - 1 < -32768); end
      5'h03: begin
        t = ua + ub + cl; r.lo = t[15:0]; r.c = (t > 65535);
        st = sa + sb + cv; r.v = (st > 32767) || (st < -32768);
      end
      5'h04: begin
        t = ua - ub - cl; r.lo = t[15:0]; r.c = (t < 0);
        st = sa - sb - cv; r.v = (st > 32767) || (st < -32768);
      end
      5'h05: r.lo = a & b;
      5'h06: r.lo = a | b;
      5'h07: r.lo = a ^ b;
      5'h08: r.lo = ~a;
      5'h09: begin t = ua * 2; r.lo = t[15:0]; r.c = t[16]; end
      5'h0A: begin t = ua / 2; r.lo = t[15:0]; r.c = (ua % 2 == 1); end
      5'h0B: begin st = sa >>> 1; r.lo = st[15:0]; r.c = (ua % 2 == 1); end
      5'h0C: begin t = ua * 2 + cl; r.lo = t[15:0]; r.c = t[16]; end
      5'h0D: begin t = ua / 2 + cl * 32768; r.lo = t[15:0]; r.c = (ua % 2 == 1); end
      5'h0E: begin t = (ua % 256) * 256 + ua / 256; r.lo = t[15:0]; end
      5'h10: begin
        t = ua * ub; r.hi = t[31:16]; r.lo = t[15:0];
        r.c = (r.hi != 0); r.v = r.c;
      end
`ifdef ALU_MC_DIV_EN
      5'h11: begin
        if (ub == 0) begin r.lo = 16'hFFFF; r.hi = a; r.v = 1; end
        else begin t = ua / ub; r.lo = t[15:0]; t = ua % ub; r.hi = t[15:0]; end
      end
`endif
      default: r.err = 1;
    endcase
    r.z = (r.hi == 0) && (r.lo == 0);
    r.s = (f == 5'h10) ? r.hi[15] : r.lo[15];
    return r;
  endfunction

  // Issue one op on the 16-bit DUT, scramble inputs after acceptance, check everything
  task automatic run_op(input logic [4:0] f, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input bit poke);
    res_t e;
    int   lat;
    int   exp_lat;
    e = model(f, a, b, ci);
    exp_lat = is_iter(f) ? 17 : 1;
    b16.start = 1'b1; b16.fsel = f; b16.abus = a; b16.bbus = b; b16.cin = ci;
    @(posedge clk); #1;
    b16.start = 1'b0; b16.fsel = 5'($urandom); b16.abus = 16'($urandom);
    b16.bbus = 16'($urandom); b16.cin = 1'($urandom);
    lat = 1;
    while (!b16.done && lat < 40) begin
      chk("busy_during_exec", 64'(b16.busy), 64'(1));
      b16.start = (poke && lat == 3);
      if (poke && lat == 3) b16.fsel = 5'h01;
      @(posedge clk); #1;
      lat++;
    end
    b16.start = 1'b0;
    $display("op fsel=%02h a=%04h b=%04h cin=%0d -> lat=%0d fout_hi=%04h fout=%04h czsv=%b%b%b%b err=%0d",
             f, a, b, ci, lat, b16.fout_hi, b16.fout, b16.c, b16.z, b16.s, b16.v, b16.err);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("fout", 64'(b16.fout), 64'(e.lo));
    chk("fout_hi", 64'(b16.fout_hi), 64'(e.hi));
    chk("flag_c", 64'(b16.c), 64'(e.c));
    chk("flag_z", 64'(b16.z), 64'(e.z));
    chk("flag_s", 64'(b16.s), 64'(e.s));
    chk("flag_v", 64'(b16.v), 64'(e.v));
    chk("err", 64'(b16.err), 64'(e.err));
    chk("busy_at_done", 64'(b16.busy), 64'(0));
    @(posedge clk); #1;
    chk("done_pulse", 64'(b16.done), 64'(0));
    chk("fout_hold", 64'(b16.fout), 64'(e.lo));
  endtask

  task automatic wait_done16(output int n);
    n = 1;
    while (!b16.done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         dcount;
    logic [4:0] f;
    logic [31:0] wa, wb;
    logic [63:0] wp;

    b16.start = 0; b16.fsel = 0; b16.abus = 0; b16.bbus = 0; b16.cin = 0;
    b32.start = 0; b32.fsel = 0; b32.abus = 0; b32.bbus = 0; b32.cin = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_busy", 64'(b16.busy), 64'(0));
    chk("rst_done", 64'(b16.done), 64'(0));
    chk("rst_err", 64'(b16.err), 64'(0));
    chk("rst_fout", 64'(b16.fout), 64'(0));
    chk("rst_fout_hi", 64'(b16.fout_hi), 64'(0));
    chk("rst_czsv", 64'({b16.c, b16.z, b16.s, b16.v}), 64'(4'b0100));
    chk("rst_z32", 64'(b32.z), 64'(1));

    run_op(5'h03, 16'h7FFF, 16'h0001, 1'b0, 0);  // signed overflow into 0x8000
    run_op(5'h10, 16'hFFFF, 16'hFFFF, 1'b0, 1);  // MUL with an ignored START mid-busy
    run_op(5'h0B, 16'hFFFF, 16'h0000, 1'b0, 0);
    run_op(5'h0F, 16'h1234, 16'h5678, 1'b1, 0);
    run_op(5'h11, 16'd100, 16'd7, 1'b0, 0);
    run_op(5'h11, 16'd5, 16'd0, 1'b0, 0);
    run_op(5'h11, 16'hFFFF, 16'h0001, 1'b0, 0);
    run_op(5'h04, 16'h8000, 16'h0001, 1'b0, 0);
    run_op(5'h04, 16'h0000, 16'h0000, 1'b1, 0);
    run_op(5'h0E, 16'hA1B2, 16'h0000, 1'b0, 0);
    run_op(5'h0C, 16'h8001, 16'h0000, 1'b1, 0);
    run_op(5'h0D, 16'h0001, 16'h0000, 1'b1, 0);
    run_op(5'h02, 16'h0000, 16'h0000, 1'b0, 0);
    run_op(5'h1F, 16'hFFFF, 16'hFFFF, 1'b1, 0);

    // Back-to-back: INC accepted on the MUL's DONE cycle
    b16.start = 1; b16.fsel = 5'h10; b16.abus = 16'h1234; b16.bbus = 16'h0003;
    @(posedge clk); #1;
    b16.start = 0;
    wait_done16(n);
    chk("b2b_mul_lat", 64'(n), 64'(17));
    chk("b2b_mul_fout", 64'(b16.fout), 64'(16'h369C));
    b16.start = 1; b16.fsel = 5'h01; b16.abus = 16'hFFFF; b16.cin = 0;
    @(posedge clk); #1;
    b16.start = 0;
    $display("b2b inc done=%0d fout=%04h c=%0d z=%0d", b16.done, b16.fout, b16.c, b16.z);
    chk("b2b_inc_done", 64'(b16.done), 64'(1));
    chk("b2b_inc_fout", 64'(b16.fout), 64'(0));
    chk("b2b_inc_c", 64'(b16.c), 64'(1));
    chk("b2b_inc_z", 64'(b16.z), 64'(1));
    @(posedge clk); #1;

    // Reset in the middle of a MUL aborts it without a DONE
    run_op(5'h03, 16'h0001, 16'h0002, 1'b0, 0);
    b16.start = 1; b16.fsel = 5'h10; b16.abus = 16'h00FF; b16.bbus = 16'h0101;
    @(posedge clk); #1;
    b16.start = 0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    $display("mid-mul reset busy=%0d done=%0d z=%0d fout=%04h", b16.busy, b16.done, b16.z, b16.fout);
    chk("abort_busy", 64'(b16.busy), 64'(0));
    chk("abort_done", 64'(b16.done), 64'(0));
    chk("abort_z", 64'(b16.z), 64'(1));
    chk("abort_fout", 64'(b16.fout), 64'(0));
    @(posedge clk); #1 rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (b16.done) dcount++;
    end
    chk("abort_no_done", 64'(dcount), 64'(0));
    run_op(5'h10, 16'h0100, 16'h0100, 1'b0, 0);

    // WIDTH=32 instance
    b32.start = 1; b32.fsel = 5'h10; b32.abus = 32'h0001_0000; b32.bbus = 32'h0001_0000;
    @(posedge clk); #1;
    b32.start = 0;
    n = 1;
    while (!b32.done && n < 60) begin @(posedge clk); #1; n++; end
    $display("w32 mul lat=%0d fout_hi=%08h fout=%08h", n, b32.fout_hi, b32.fout);
    chk("w32_lat", 64'(n), 64'(33));
    chk("w32_hi", 64'(b32.fout_hi), 64'(1));
    chk("w32_lo", 64'(b32.fout), 64'(0));
    chk("w32_cv", 64'({b32.c, b32.v, b32.z}), 64'(3'b110));
    for (int k = 0; k < 4; k++) begin
      wa = $urandom; wb = $urandom;
      wp = {32'b0, wa} * {32'b0, wb};
      b32.start = 1; b32.abus = wa; b32.bbus = wb;
      @(posedge clk); #1;
      b32.start = 0;
      n = 1;
      while (!b32.done && n < 60) begin @(posedge clk); #1; n++; end
      $display("w32 mul a=%08h b=%08h -> %08h_%08h", wa, wb, b32.fout_hi, b32.fout);
      chk("w32_rand_prod", {b32.fout_hi, b32.fout}, wp);
    end

    for (int k = 0; k < 60; k++) begin
      f = 5'($urandom_range(0, 31));
      if (k % 6 == 0) f = 5'h10;
      if (k % 6 == 3) f = 5'h11;
      run_op(f, 16'($urandom), (k % 12 == 3) ? 16'h0 : 16'($urandom), 1'($urandom), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
